seq_state_monitor: RTL and testbench

- Passive checker on the consuming side of a 4-state sequencer interface (2-bit state code plus an N-bit run counter).
- Each cycle it samples the sequencer's state and count and predicts the next legal pair with its own enum FSM.
- It flags protocol violations and counts completed laps.
- Used in-fabric and in benches to validate any IDLE/RUN/WAIT/DONE producer.

---
 rtl/seq_state_monitor.sv | 195 +++++++++++++++++++
 tb/tb_seq_state_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_state_monitor.sv
// seq_state_monitor
//   Passive checker for an IDLE/RUN/WAIT/DONE sequencer interface. It follows
//   the producer's (state, count) stream with its own FSM, predicts the next
//   legal pair, flags protocol violations and counts completed laps.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   en          sample enable; samples with en low are ignored
//   obs_state   observed state code (0 IDLE, 1 RUN, 2 WAIT, 3 DONE)
//   obs_count   observed run counter
//   locked      monitor is synchronised to the producer
//   err         one-cycle pulse per violation
//   err_code    last error code (0 none, 1 state mismatch, 2 count mismatch)
//   err_count   saturating violation counter
//   pass_count  completed laps, wraps mod 2^16
//
// All outputs are registered: they reflect the sample taken on the previous edge.

module seq_state_monitor #(
    parameter int unsigned RUN_LEN   = 10,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           obs_state,
    input  logic [CNT_W-1:0]     obs_count,
    output logic                 locked,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [15:0]          pass_count
);

    localparam logic [1:0] CodeIdle = 2'd0;
    localparam logic [1:0] CodeRun  = 2'd1;
    localparam logic [1:0] CodeWait = 2'd2;
    localparam logic [1:0] CodeDone = 2'd3;

    localparam logic [1:0] ErrNone  = 2'd0;
    localparam logic [1:0] ErrState = 2'd1;
    localparam logic [1:0] ErrCount = 2'd2;

    localparam logic [CNT_W-1:0] RunLast = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] RunEnd  = CNT_W'(RUN_LEN);

    localparam logic [ERR_CNT_W-1:0] ErrCntMax = {ERR_CNT_W{1'b1}};

    // Each locked state names the producer state expected on the next sample.
    typedef enum logic [2:0] {
        M_UNLOCK,
        M_IDLE,
        M_RUN,
        M_WAIT,
        M_DONE
    } mstate_e;

    mstate_e              state_q, state_d;
    logic [CNT_W-1:0]     exp_cnt_q, exp_cnt_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [15:0]          pass_count_q, pass_count_d;

    logic [1:0] exp_code;
    logic       checking;
    logic       state_err;
    logic       count_err;
    logic       lock_hit;
    logic       lap_done;

    always_comb begin
        exp_code = CodeIdle;
        case (state_q)
            M_IDLE:  exp_code = CodeIdle;
            M_RUN:   exp_code = CodeRun;
            M_WAIT:  exp_code = CodeWait;
            M_DONE:  exp_code = CodeDone;
            default: exp_code = CodeIdle;
        endcase
    end

    // State mismatch wins over count mismatch.
    assign checking  = en && (state_q != M_UNLOCK);
    assign state_err = checking && (obs_state != exp_code);
    assign count_err = checking && !state_err && (obs_count != exp_cnt_q);
    assign lock_hit  = en && (state_q == M_UNLOCK) && (obs_state == CodeIdle) &&
                       (obs_count == '0);
    assign lap_done  = checking && !state_err && !count_err && (state_q == M_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= M_UNLOCK;
            exp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            exp_cnt_q <= exp_cnt_d;
        end
    end

    // Next-state / prediction
    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        if (en) begin
            if (state_q == M_UNLOCK) begin
                if (lock_hit) begin
                    state_d   = M_RUN;
                    exp_cnt_d = '0;
                end
            end else if (state_err || count_err) begin
                // The offending sample is discarded; relock starts on the next one.
                state_d   = M_UNLOCK;
                exp_cnt_d = '0;
            end else begin
                case (state_q)
                    M_IDLE: begin
                        state_d   = M_RUN;
                        exp_cnt_d = '0;
                    end
                    M_RUN: begin
                        if (exp_cnt_q == RunLast) begin
                            state_d   = M_WAIT;
                            exp_cnt_d = RunEnd;
                        end else begin
                            exp_cnt_d = exp_cnt_q + CNT_W'(1);
                        end
                    end
                    M_WAIT: begin
                        state_d   = M_DONE;
                        exp_cnt_d = RunEnd;
                    end
                    M_DONE: begin
                        state_d   = M_IDLE;
                        exp_cnt_d = '0;
                    end
                    default: begin
                        state_d   = M_UNLOCK;
                        exp_cnt_d = '0;
                    end
                endcase
            end
        end
    end

    // Output next values
    always_comb begin
        locked_d     = locked_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        err_count_d  = err_count_q;
        pass_count_d = pass_count_q;
        if (lock_hit) begin
            locked_d = 1'b1;
        end
        if (state_err || count_err) begin
            locked_d   = 1'b0;
            err_d      = 1'b1;
            err_code_d = state_err ? ErrState : ErrCount;
            if (err_count_q != ErrCntMax) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end
        end
        if (lap_done) begin
            pass_count_d = pass_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ErrNone;
            err_count_q  <= '0;
            pass_count_q <= '0;
        end else begin
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_count_q  <= err_count_d;
            pass_count_q <= pass_count_d;
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign err_count  = err_count_q;
    assign pass_count = pass_count_q;

endmodule

// File: tb/tb_seq_state_monitor.sv
// Scoreboard bench for seq_state_monitor. Two instances share one stimulus
// stream: default widths, and ERR_CNT_W=2 to exercise counter saturation.
// The driver pushes hand-annotated expected outputs per sample; a monitor
// pops one entry after every clock edge and compares.

module tb_seq_state_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  obs_state = 2'd0;
    logic [7:0]  obs_count = 8'd0;

    logic        locked_a, err_a, locked_b, err_b;
    logic [1:0]  err_code_a, err_code_b;
    logic [7:0]  err_count_a;
    logic [1:0]  err_count_b;
    logic [15:0] pass_count_a, pass_count_b;

    seq_state_monitor #(.RUN_LEN(10), .CNT_W(8), .ERR_CNT_W(8)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .obs_state  (obs_state),
        .obs_count  (obs_count),
        .locked     (locked_a),
        .err        (err_a),
        .err_code   (err_code_a),
        .err_count  (err_count_a),
        .pass_count (pass_count_a)
    );

    seq_state_monitor #(.RUN_LEN(10), .CNT_W(8), .ERR_CNT_W(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .obs_state  (obs_state),
        .obs_count  (obs_count),
        .locked     (locked_b),
        .err        (err_b),
        .err_code   (err_code_b),
        .err_count  (err_count_b),
        .pass_count (pass_count_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   vec;
        bit   lock;
        bit   err;
        int   code;
        int   errs;
        int   pass;
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int vec_no  = 0;

    // Expected-output state, updated only from hand annotations.
    bit m_locked = 1'b0;
    int m_code   = 0;
    int m_errs   = 0;
    int m_pass   = 0;

    task automatic chk(input string name, input int vec, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec=%0d: got %0d, expected %0d", name, vec, act, req);
        end
    endtask

    // Monitor: outputs for a sample are valid after the edge that took it.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("locked_a",     x.vec, {31'd0, locked_a}, {31'd0, x.lock});
                chk("locked_b",     x.vec, {31'd0, locked_b}, {31'd0, x.lock});
                chk("err_a",        x.vec, {31'd0, err_a}, {31'd0, x.err});
                chk("err_b",        x.vec, {31'd0, err_b}, {31'd0, x.err});
                chk("err_code",     x.vec, {30'd0, err_code_a}, x.code);
                chk("err_code_b",   x.vec, {30'd0, err_code_b}, x.code);
                chk("err_count8",   x.vec, {24'd0, err_count_a},
                    (x.errs > 255) ? 255 : x.errs);
                chk("err_count2",   x.vec, {30'd0, err_count_b},
                    (x.errs > 3) ? 3 : x.errs);
                chk("pass_count",   x.vec, {16'd0, pass_count_a}, x.pass & 16'hFFFF);
                chk("pass_count_b", x.vec, {16'd0, pass_count_b}, x.pass & 16'hFFFF);
            end
        end
    end

    // One sample: r/e/s/c stimulus, then expected lock, err pulse, new err code, lap flag.
    task automatic drive(input bit r, input bit e, input logic [1:0] s,
                         input logic [7:0] c, input bit xl, input bit xe,
                         input int xc, input bit xp);
        exp_t x;
        @(negedge clk);
        rst       = r;
        en        = e;
        obs_state = s;
        obs_count = c;
        if (r) begin
            m_locked = 1'b0;
            m_code   = 0;
            m_errs   = 0;
            m_pass   = 0;
        end else begin
            m_locked = xl;
            if (xe) begin
                m_errs++;
                m_code = xc;
            end
            if (xp) m_pass++;
        end
        x.vec  = vec_no;
        x.lock = m_locked;
        x.err  = xe && !r;
        x.code = m_code;
        x.errs = m_errs;
        x.pass = m_pass;
        q.push_back(x);
        vec_no++;
    endtask

    task automatic ok(input logic [1:0] s, input logic [7:0] c, input bit lap_end);
        drive(1'b0, 1'b1, s, c, 1'b1, 1'b0, 0, lap_end);
    endtask

    task automatic unl(input logic [1:0] s, input logic [7:0] c);
        drive(1'b0, 1'b1, s, c, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic bad(input logic [1:0] s, input logic [7:0] c, input int code);
        drive(1'b0, 1'b1, s, c, 1'b0, 1'b1, code, 1'b0);
    endtask

    task automatic reset_cycle();
        drive(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic hold();
        drive(1'b0, 1'b0, 2'($urandom_range(3)), 8'($urandom_range(255)),
              m_locked, 1'b0, 0, 1'b0);
    endtask

    task automatic runs(input int a, input int b);
        for (int i = a; i <= b; i++) ok(2'd1, 8'(i), 1'b0);
    endtask

    task automatic lap();
        ok(2'd0, 8'd0, 1'b0);
        runs(0, 9);
        ok(2'd2, 8'd10, 1'b0);
        ok(2'd3, 8'd10, 1'b1);
    endtask

    initial begin
        // Reset values, then junk that must not lock: DONE/10, IDLE/5.
        reset_cycle();
        reset_cycle();
        unl(2'd3, 8'd10);
        unl(2'd0, 8'd5);
        // Clean producer, three laps.
        lap();
        lap();
        lap();

        // RUN/4 -> DONE/10 jump: state mismatch, then relock at IDLE/0.
        reset_cycle();
        ok(2'd0, 8'd0, 1'b0);
        runs(0, 4);
        bad(2'd3, 8'd10, 1);
        lap();

        // RUN/5 where RUN/4 expected: count mismatch; rest of lap not counted.
        reset_cycle();
        ok(2'd0, 8'd0, 1'b0);
        runs(0, 3);
        bad(2'd1, 8'd5, 2);
        for (int i = 6; i <= 9; i++) unl(2'd1, 8'(i));
        unl(2'd2, 8'd10);
        unl(2'd3, 8'd10);
        lap();

        // Stream starts mid-lap at RUN/3.
        reset_cycle();
        for (int i = 3; i <= 9; i++) unl(2'd1, 8'(i));
        unl(2'd2, 8'd10);
        unl(2'd3, 8'd10);
        lap();

        // en low for 5 cycles inside a locked lap.
        reset_cycle();
        ok(2'd0, 8'd0, 1'b0);
        runs(0, 4);
        for (int i = 0; i < 5; i++) hold();
        runs(5, 9);
        ok(2'd2, 8'd10, 1'b0);
        ok(2'd3, 8'd10, 1'b1);
        ok(2'd0, 8'd0, 1'b0);

        // Five violations, each after a relock; second DUT saturates at 3.
        reset_cycle();
        for (int i = 0; i < 5; i++) begin
            ok(2'd0, 8'd0, 1'b0);
            ok(2'd1, 8'd0, 1'b0);
            if (i % 2 == 0) bad(2'd2, 8'd10, 1);
            else            bad(2'd1, 8'd7, 2);
        end
        // Wrong count while expecting WAIT.
        ok(2'd0, 8'd0, 1'b0);
        runs(0, 9);
        bad(2'd2, 8'd9, 2);
        // Mid-lap reset.
        ok(2'd0, 8'd0, 1'b0);
        runs(0, 2);
        reset_cycle();
        ok(2'd0, 8'd0, 1'b0);
        ok(2'd1, 8'd0, 1'b0);

        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #3;
        chk("scoreboard_drained", vec_no, q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
